// File: rtl/divider_32bit_seq.sv
// Unsigned restoring divider, one quotient bit per clock; done WIDTH+1 cycles after an accepted start (1 for divisor == 0).
// No backpressure: start is taken only in IDLE/DONE and ignored while busy; results hold until the next accepted start.
module divider_32bit_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   q_q, q_d;
    // The kept remainder is always below the divisor, so WIDTH bits hold it;
    // only the shifted trial operand needs the extra bit.
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     r_shift;
    logic [WIDTH-1:0]   t_sum;
    logic               add_cout;

    // Ripple-carry add over WIDTH+1 bits; only the low WIDTH sum bits and the carry are needed.
    function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH:0] a,
                                                  input logic [WIDTH:0] b,
                                                  input logic           cin);
        logic             c;
        logic [WIDTH-1:0] s;
        c = cin;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c = (a[WIDTH] & b[WIDTH]) | (c & (a[WIDTH] ^ b[WIDTH]));
        return {c, s};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        r_shift           = {r_q, q_q[WIDTH-1]};
        {add_cout, t_sum} = ripple_add(r_shift, ~{1'b0, dvs_q}, 1'b1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvs_d  = divisor;
                    q_d    = dividend;
                    r_d    = '0;
                    cnt_d  = CNT_W'(WIDTH);
                    quot_d = '0;
                    rem_d  = '0;
                    dbz_d  = 1'b0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // carry out set means no borrow: the trial subtraction fits
                r_d   = add_cout ? t_sum : r_shift[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], add_cout};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    quot_d  = q_d;
                    rem_d   = r_d;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign divByZero = dbz_q;

endmodule

// File: doc/divider_32bit_seq.md
Name: divider_32bit_seq

Overview:
- Multi-cycle unsigned restoring divider: quotient = dividend / divisor, remainder = dividend mod divisor.
- Produces one quotient bit per clock.
- Trial subtraction reuses the team's ripple adder: divisor inverted, carryIn = 1.
- Sits beside the combinational ALU as the slow-path datapath unit, with a start/busy/done handshake toward the control unit.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  WIDTH  numerator; captured on the accepted start edge
- divisor  input  WIDTH  denominator; captured on the accepted start edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  result quotient; held until the next accepted start
- remainder  output  WIDTH  result remainder; held until the next accepted start
- divByZero  output  1  set with done when the captured divisor == 0; held with the results

Behaviour:
- Reset: asynchronous, active-high; reset is one clock; reset is asynchronous and active-high.
  - Asserting reset forces state = IDLE and all of busy, done, quotient, remainder, divByZero and internal registers to 0, at any time including mid-RUN.
  - No partial result survives reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at an edge: capture operands, clear divByZero and the done-side outputs, load the counter with WIDTH.
  - If divisor != 0: go to RUN.
  - If divisor == 0: go directly to DONE with quotient = all ones, remainder = dividend, divByZero = 1.
- RUN (busy = 1): one iteration per edge.
  - Shift the partial remainder R (WIDTH+1 bits) left, bringing in the MSB of the working dividend/quotient register Q.
  - Shift Q left.
  - Form T = R + ~{0, D} + 1.
  - If the adder carryOut = 1 (no borrow): R <= T and Q[0] <= 1. Otherwise R is kept and Q[0] <= 0.
  - Decrement the counter; after the WIDTH-th iteration go to DONE.
- DONE:
  - done = 1 for exactly this cycle; quotient <= Q, remainder <= R[WIDTH-1:0].
  - Next state: IDLE, or RUN / DONE directly if start = 1 on this edge (back-to-back operation, same rules as IDLE).
- Latency: accepted start at edge k.
  - Nonzero divisor: busy high in the cycles following edges k..k+WIDTH-1; done high in the cycle following edge k+WIDTH (WIDTH+1 cycles after acceptance, 33 for WIDTH = 32).
  - Zero divisor: done in the cycle following edge k+1... is not used; done is high in the cycle immediately following edge k.
- start while busy: ignored; operands are not recaptured and the operation continues undisturbed.
- Operand changes after capture have no effect.
- Outputs quotient, remainder and divByZero change only on entry to DONE, on an accepted start (the clear), or on reset.
- Arithmetic is purely unsigned.
  - dividend < divisor → quotient 0, remainder dividend.
  - dividend = 0 → quotient 0, remainder 0.
- Invariant on done (divisor != 0): quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Reset released, start with 100 / 7 → busy for 32 cycles; done pulses once, 33 cycles after the start edge; quotient = 14, remainder = 2, divByZero = 0.
- 0xFFFFFFFF / 1 followed back-to-back (start held in the DONE cycle) by 0xFFFFFFFF / 0x10000 → first result q = 0xFFFFFFFF, r = 0; second q = 0xFFFF, r = 0xFFFF; no IDLE cycle between the two operations.
- 5 / 0 → done in the cycle after the start edge, divByZero = 1, quotient = 0xFFFFFFFF, remainder = 5, busy never high.
- 3 / 10, then 0 / 9 → q = 0, r = 3; then q = 0, r = 0.
- During RUN of 1000 / 3: pulse start with 8 / 2 and change the operand inputs → ignored; result q = 333, r = 1.
- Assert reset 10 cycles into RUN of 50 / 5 → all outputs 0 immediately, state IDLE. Restart with 50 / 5 → q = 10, r = 0.
